// File: rtl/sdram_arbiter.sv
// SDRAM master arbiter: display line-refill bursts have absolute priority,
// the drawing engine (client 0) and CPU (client 1) share the rest round-robin.
module sdram_arbiter #(
  parameter int BURST_LEN = 640,
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  output logic          disp_done,
  output logic          burst_err,
  input  logic [1:0]    c_req,
  input  logic [1:0]    c_we,
  input  logic [AW-1:0] c_addr0,
  input  logic [AW-1:0] c_addr1,
  input  logic [DW-1:0] c_wdata0,
  input  logic [DW-1:0] c_wdata1,
  output logic [1:0]    c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          mm_read_req,
  output logic          mm_write_req,
  output logic          mm_burst_req,
  output logic [AW-1:0] mm_address,
  output logic [DW-1:0] mm_write_data,
  input  logic          mm_ready,
  input  logic          mm_burst_finished,
  input  logic [DW-1:0] mm_data
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    SINGLE
  } state_t;

  state_t        state_q;
  logic          rr_last_q;
  logic          gnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [10:0]   beat_cnt_q;
  logic          burst_err_q;
  logic [1:0]    c_ack_q;
  logic [DW-1:0] c_rdata_q;
  logic          disp_done_q;

  logic          gnt_d;
  logic [10:0]   beat_cnt_d;
  logic [11:0]   beat_total;

  // With both clients asking, the one not served last time wins.
  always_comb begin
    gnt_d = c_req[1];
    if (c_req == 2'b11) begin
      gnt_d = ~rr_last_q;
    end
  end

  assign beat_cnt_d = (beat_cnt_q == 11'h7FF) ? beat_cnt_q : beat_cnt_q + 11'd1;
  assign beat_total = {1'b0, beat_cnt_q} + 12'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
      c_ack_q     <= '0;
      c_rdata_q   <= '0;
      disp_done_q <= 1'b0;
    end else begin
      c_ack_q     <= '0;
      disp_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (disp_req) begin
            state_q    <= BURST;
            addr_q     <= disp_addr;
            beat_cnt_q <= '0;
          end else if (|c_req) begin
            state_q   <= SINGLE;
            gnt_q     <= gnt_d;
            rr_last_q <= gnt_d;
            addr_q    <= gnt_d ? c_addr1 : c_addr0;
            wdata_q   <= gnt_d ? c_wdata1 : c_wdata0;
            we_q      <= c_we[gnt_d];
          end
        end
        BURST: begin
          if (mm_ready) begin
            beat_cnt_q <= beat_cnt_d;
          end
          // The finishing beat is not yet in beat_cnt_q, hence the +1.
          if (mm_burst_finished) begin
            state_q     <= IDLE;
            disp_done_q <= 1'b1;
            if (beat_total != 12'(BURST_LEN)) begin
              burst_err_q <= 1'b1;
            end
          end
        end
        SINGLE: begin
          if (mm_ready) begin
            state_q <= IDLE;
            c_ack_q <= gnt_q ? 2'b10 : 2'b01;
            if (!we_q) begin
              c_rdata_q <= mm_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mm_burst_req  = (state_q == BURST);
  assign mm_write_req  = (state_q == SINGLE) && we_q;
  assign mm_read_req   = (state_q == SINGLE) && !we_q;
  assign mm_address    = addr_q;
  assign mm_write_data = wdata_q;

  assign disp_valid = (state_q == BURST) && mm_ready;
  assign disp_data  = (state_q == BURST) ? mm_data : '0;
  assign disp_done  = disp_done_q;
  assign burst_err  = burst_err_q;
  assign c_ack      = c_ack_q;
  assign c_rdata    = c_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed clients and a behavioural memory
// master feed expected-response queues that a negedge monitor drains.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BURST_LEN = 640;

  localparam logic [2:0] KIND_RD = 3'b001;
  localparam logic [2:0] KIND_WR = 3'b010;
  localparam logic [2:0] KIND_BU = 3'b100;

  logic          Clk;
  logic          Reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          disp_done;
  logic          burst_err;
  logic [1:0]    c_req;
  logic [1:0]    c_we;
  logic [AW-1:0] c_addr0;
  logic [AW-1:0] c_addr1;
  logic [DW-1:0] c_wdata0;
  logic [DW-1:0] c_wdata1;
  logic [1:0]    c_ack;
  logic [DW-1:0] c_rdata;
  logic          mm_read_req;
  logic          mm_write_req;
  logic          mm_burst_req;
  logic [AW-1:0] mm_address;
  logic [DW-1:0] mm_write_data;
  logic          mm_ready;
  logic          mm_burst_finished;
  logic [DW-1:0] mm_data;

  typedef struct {
    logic [2:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
  } ack_t;

  typedef struct {
    int   beats;
    logic err;
  } done_t;

  req_t  expReq[$];
  ack_t  expAck[$];
  done_t expDone[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int singleLatency = 1;
  int burstBeats = BURST_LEN;
  logic [DW-1:0] readWord = '0;
  logic [DW-1:0] burstBase = '0;
  int beatsSeen = 0;
  int reqCount0 = 0;
  int reqCount1 = 0;
  int dispCount = 0;

  sdram_arbiter #(
    .BURST_LEN(BURST_LEN),
    .AW(AW),
    .DW(DW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_valid(disp_valid),
    .disp_data(disp_data),
    .disp_done(disp_done),
    .burst_err(burst_err),
    .c_req(c_req),
    .c_we(c_we),
    .c_addr0(c_addr0),
    .c_addr1(c_addr1),
    .c_wdata0(c_wdata0),
    .c_wdata1(c_wdata1),
    .c_ack(c_ack),
    .c_rdata(c_rdata),
    .mm_read_req(mm_read_req),
    .mm_write_req(mm_write_req),
    .mm_burst_req(mm_burst_req),
    .mm_address(mm_address),
    .mm_write_data(mm_write_data),
    .mm_ready(mm_ready),
    .mm_burst_finished(mm_burst_finished),
    .mm_data(mm_data)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic expectReq(input logic [2:0] kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.kind = kind;
    r.addr = addr;
    r.wdata = wdata;
    expReq.push_back(r);
  endtask

  task automatic expectAck(input logic [1:0] ack, input logic [DW-1:0] rdata);
    ack_t a;
    a.ack = ack;
    a.rdata = rdata;
    expAck.push_back(a);
  endtask

  task automatic expectDone(input int beats, input logic err);
    done_t d;
    d.beats = beats;
    d.err = err;
    expDone.push_back(d);
  endtask

  task automatic cycleCounter();
    forever begin
      @(posedge Clk);
      cycle++;
    end
  endtask

  // Memory master: singles complete after singleLatency request cycles, bursts stream one beat per cycle.
  task automatic masterModel();
    int waitCnt = 0;
    int beatIdx = 0;
    forever begin
      @(posedge Clk);
      #1;
      mm_ready = 1'b0;
      mm_burst_finished = 1'b0;
      mm_data = '0;
      if (Reset) begin
        waitCnt = 0;
        beatIdx = 0;
      end else if (mm_read_req || mm_write_req) begin
        waitCnt++;
        if (waitCnt >= singleLatency) begin
          mm_ready = 1'b1;
          mm_data = readWord;
          waitCnt = 0;
        end
      end else if (mm_burst_req) begin
        mm_ready = 1'b1;
        mm_data = burstBase + DW'(beatIdx);
        beatIdx++;
        if (beatIdx >= burstBeats) begin
          mm_burst_finished = 1'b1;
          beatIdx = 0;
        end
      end else begin
        waitCnt = 0;
        beatIdx = 0;
      end
    end
  endtask

  task automatic monitorLoop();
    logic [2:0] prevReq = '0;
    logic [2:0] curReq;
    logic gapDue = 1'b0;
    int readyCycle = -10;
    int finishCycle = -10;
    int beatDataErr = 0;
    req_t r;
    ack_t a;
    done_t d;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prevReq = '0;
        gapDue = 1'b0;
        beatsSeen = 0;
        beatDataErr = 0;
        continue;
      end
      curReq = {mm_burst_req, mm_write_req, mm_read_req};
      if (gapDue) checkOutput("reqGapAfterDone", 64'(curReq), 64'(0));
      gapDue = ((mm_read_req || mm_write_req) && mm_ready) || (mm_burst_req && mm_burst_finished);
      if (curReq != 3'b000 && prevReq == 3'b000) begin
        if (expReq.size() == 0) begin
          checkOutput("unexpectedReq", 64'(curReq), 64'(0));
        end else begin
          r = expReq.pop_front();
          checkOutput("reqKind", 64'(curReq), 64'(r.kind));
          checkOutput("reqAddr", 64'(mm_address), 64'(r.addr));
          if (r.kind == KIND_WR) checkOutput("reqWdata", 64'(mm_write_data), 64'(r.wdata));
        end
      end
      prevReq = curReq;
      if ((mm_read_req || mm_write_req) && mm_ready) readyCycle = cycle;
      if (mm_burst_req && mm_burst_finished) finishCycle = cycle;
      if (disp_valid) begin
        if (disp_data !== burstBase + DW'(beatsSeen)) beatDataErr++;
        beatsSeen++;
      end
      if (disp_done) begin
        if (expDone.size() == 0) begin
          checkOutput("unexpectedDone", 64'(disp_done), 64'(0));
        end else begin
          d = expDone.pop_front();
          checkOutput("burstBeats", 64'(beatsSeen), 64'(d.beats));
          checkOutput("burstErr", 64'(burst_err), 64'(d.err));
          checkOutput("doneLatency", 64'(cycle), 64'(finishCycle + 1));
          checkOutput("burstDataErrs", 64'(beatDataErr), 64'(0));
        end
        beatsSeen = 0;
        beatDataErr = 0;
      end
      if (c_ack != 2'b00) begin
        if (expAck.size() == 0) begin
          checkOutput("unexpectedAck", 64'(c_ack), 64'(0));
        end else begin
          a = expAck.pop_front();
          checkOutput("ackClient", 64'(c_ack), 64'(a.ack));
          checkOutput("ackRdata", 64'(c_rdata), 64'(a.rdata));
          checkOutput("ackLatency", 64'(cycle), 64'(readyCycle + 1));
        end
      end
    end
  endtask

  // Clients hold their requests until the last expected ack / disp_done, then drop them.
  task automatic stepCycle();
    @(negedge Clk);
    #2;
    if (c_ack[0] && reqCount0 > 0) begin
      reqCount0--;
      if (reqCount0 == 0) c_req[0] = 1'b0;
    end
    if (c_ack[1] && reqCount1 > 0) begin
      reqCount1--;
      if (reqCount1 == 0) c_req[1] = 1'b0;
    end
    if (disp_done && dispCount > 0) begin
      dispCount--;
      if (dispCount == 0) disp_req = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int n0, input int n1, input int nDisp);
    reqCount0 = n0;
    reqCount1 = n1;
    dispCount = nDisp;
    c_req = {n1 > 0, n0 > 0};
    disp_req = (nDisp > 0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expReq.size() != 0 || expAck.size() != 0 || expDone.size() != 0 ||
            c_req != 2'b00 || disp_req) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("queuesDrained", 64'(expReq.size() + expAck.size() + expDone.size()), 64'(0));
    repeat (2) stepCycle();
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    disp_req = 1'b0;
    disp_addr = '0;
    c_req = '0;
    c_we = '0;
    c_addr0 = '0;
    c_addr1 = '0;
    c_wdata0 = '0;
    c_wdata1 = '0;
    mm_ready = 1'b0;
    mm_burst_finished = 1'b0;
    mm_data = '0;
    fork
      cycleCounter();
      masterModel();
      monitorLoop();
    join_none

    repeat (3) @(negedge Clk);
    #2;
    checkOutput("rstDispValid", 64'(disp_valid), 64'(0));
    checkOutput("rstDispData", 64'(disp_data), 64'(0));
    checkOutput("rstDispDone", 64'(disp_done), 64'(0));
    checkOutput("rstBurstErr", 64'(burst_err), 64'(0));
    checkOutput("rstCAck", 64'(c_ack), 64'(0));
    checkOutput("rstCRdata", 64'(c_rdata), 64'(0));
    checkOutput("rstMmReqs", 64'({mm_burst_req, mm_write_req, mm_read_req}), 64'(0));
    checkOutput("rstMmAddress", 64'(mm_address), 64'(0));
    checkOutput("rstMmWdata", 64'(mm_write_data), 64'(0));
    Reset = 1'b0;
    repeat (2) stepCycle();

    $display("[TB] single write, client 0");
    c_addr0 = 25'h00010;
    c_wdata0 = 32'hDEADBEEF;
    c_we = 2'b01;
    singleLatency = 3;
    expectReq(KIND_WR, 25'h00010, 32'hDEADBEEF);
    expectAck(2'b01, 32'h0);
    applyStimulus(1, 0, 0);
    waitDrain(200);

    $display("[TB] single read, client 1");
    c_addr1 = 25'h1F000;
    c_we = 2'b00;
    readWord = 32'h12345678;
    singleLatency = 2;
    expectReq(KIND_RD, 25'h1F000, 32'h0);
    expectAck(2'b10, 32'h12345678);
    applyStimulus(0, 1, 0);
    waitDrain(200);
    checkOutput("rdataHeld", 64'(c_rdata), 64'(32'h12345678));

    $display("[TB] round-robin with both clients held");
    c_addr0 = 25'h00100;
    c_wdata0 = 32'hA5A5A5A5;
    c_addr1 = 25'h00200;
    c_we = 2'b01;
    readWord = 32'hCAFE0001;
    singleLatency = 1;
    expectReq(KIND_WR, 25'h00100, 32'hA5A5A5A5);
    expectReq(KIND_RD, 25'h00200, 32'h0);
    expectReq(KIND_WR, 25'h00100, 32'hA5A5A5A5);
    expectReq(KIND_RD, 25'h00200, 32'h0);
    expectAck(2'b01, 32'h12345678);
    expectAck(2'b10, 32'hCAFE0001);
    expectAck(2'b01, 32'hCAFE0001);
    expectAck(2'b10, 32'hCAFE0001);
    applyStimulus(2, 2, 0);
    waitDrain(200);

    $display("[TB] display priority over both clients");
    disp_addr = 25'h0A000;
    burstBase = 32'h50000000;
    burstBeats = 640;
    c_addr0 = 25'h00300;
    c_addr1 = 25'h00400;
    c_wdata1 = 32'h11112222;
    c_we = 2'b10;
    readWord = 32'h77778888;
    singleLatency = 2;
    expectReq(KIND_BU, 25'h0A000, 32'h0);
    expectReq(KIND_RD, 25'h00300, 32'h0);
    expectReq(KIND_WR, 25'h00400, 32'h11112222);
    expectDone(640, 1'b0);
    expectAck(2'b01, 32'h77778888);
    expectAck(2'b10, 32'h77778888);
    applyStimulus(1, 1, 1);
    waitDrain(2000);

    $display("[TB] short burst then good burst");
    disp_addr = 25'h0B000;
    burstBase = 32'h60000000;
    burstBeats = 639;
    expectReq(KIND_BU, 25'h0B000, 32'h0);
    expectDone(639, 1'b1);
    applyStimulus(0, 0, 1);
    waitDrain(2000);
    disp_addr = 25'h0C000;
    burstBase = 32'h70000000;
    burstBeats = 640;
    expectReq(KIND_BU, 25'h0C000, 32'h0);
    expectDone(640, 1'b1);
    applyStimulus(0, 0, 1);
    waitDrain(2000);
    checkOutput("burstErrSticky", 64'(burst_err), 64'(1));

    $display("[TB] reset during burst with client 1 pending");
    disp_addr = 25'h0D000;
    burstBase = 32'h80000000;
    burstBeats = 640;
    c_addr1 = 25'h1ABCD;
    c_we = 2'b00;
    readWord = 32'h0BADF00D;
    singleLatency = 4;
    expectReq(KIND_BU, 25'h0D000, 32'h0);
    applyStimulus(0, 1, 1);
    n = 0;
    while (beatsSeen < 100 && n < 1000) begin
      stepCycle();
      n++;
    end
    checkOutput("beat100Reached", 64'(beatsSeen), 64'(100));
    Reset = 1'b1;
    dispCount = 0;
    disp_req = 1'b0;
    #1;
    checkOutput("midRstMmReqs", 64'({mm_burst_req, mm_write_req, mm_read_req}), 64'(0));
    checkOutput("midRstDispValid", 64'(disp_valid), 64'(0));
    checkOutput("midRstDispDone", 64'(disp_done), 64'(0));
    checkOutput("midRstBurstErr", 64'(burst_err), 64'(0));
    repeat (2) stepCycle();
    Reset = 1'b0;
    expectReq(KIND_RD, 25'h1ABCD, 32'h0);
    expectAck(2'b10, 32'h0BADF00D);
    waitDrain(200);
    checkOutput("postRstBurstErr", 64'(burst_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
